// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter
//   General-purpose timer/event counter with a programmable prescaler,
//   up/down counting, a programmable limit and four terminal-count modes
//   (wrap, saturate, one-shot, auto-reload).
//
// Ports
//   Clock          system clock; all state updates on posedge
//   Reset          synchronous, active-high reset
//   Enable         advances the prescaler and allows counting; 0 holds all state
//   Load           loads LoadValue into Q; clears prescaler, Done and one-shot freeze
//   LoadValue      load value and auto-reload value
//   Direction      0 = count up, 1 = count down
//   Mode           00 wrap, 01 saturate, 10 one-shot, 11 auto-reload
//   Limit          up-count terminal value; wrap target when counting down
//   Prescale       a step occurs every Prescale+1 enabled cycles
//   Q              current count
//   TerminalCount  registered one-cycle pulse after a step taken at the terminal value
//   Done           sticky flag, set at the first terminal event
module prescaled_updown_counter #(
  parameter int SIZE          = 16,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic                     Load,
  input  logic [SIZE-1:0]          LoadValue,
  input  logic                     Direction,
  input  logic [1:0]               Mode,
  input  logic [SIZE-1:0]          Limit,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  output logic [SIZE-1:0]          Q,
  output logic                     TerminalCount,
  output logic                     Done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SATURATE = 2'b01,
    MODE_ONE_SHOT = 2'b10,
    MODE_RELOAD   = 2'b11
  } mode_t;

  // A one-shot counter that has fired sits in FROZEN until Load or Reset.
  typedef enum logic {
    RUNNING = 1'b0,
    FROZEN  = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [SIZE-1:0]          q, q_next;
  logic [PRESCALE_BITS-1:0] pcnt, pcnt_next;
  logic                     tc, tc_next;
  logic                     done, done_next;

  logic active;
  logic tick;
  logic at_term;
  mode_t mode;

  assign mode    = mode_t'(Mode);
  assign active  = Enable && (state == RUNNING);
  assign tick    = active && (pcnt == Prescale);
  assign at_term = Direction ? (q == '0) : (q == Limit);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    q_next     = q;
    pcnt_next  = pcnt;
    tc_next    = 1'b0;
    done_next  = done;

    if (Load) begin
      q_next     = LoadValue;
      pcnt_next  = '0;
      done_next  = 1'b0;
      state_next = RUNNING;
    end else if (active) begin
      // A Prescale lowered below pcnt lets pcnt run on and wrap through
      // 2^PRESCALE_BITS before the next match.
      pcnt_next = tick ? '0 : pcnt + 1'b1;

      if (tick) begin
        if (!at_term) begin
          q_next = Direction ? q - 1'b1 : q + 1'b1;
        end else begin
          tc_next   = 1'b1;
          done_next = 1'b1;
          unique case (mode)
            MODE_WRAP:     q_next = Direction ? Limit : '0;
            MODE_SATURATE: q_next = q;
            MODE_ONE_SHOT: state_next = FROZEN;
            MODE_RELOAD:   q_next = LoadValue;
          endcase
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RUNNING;
      q     <= '0;
      pcnt  <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      pcnt  <= pcnt_next;
      tc    <= tc_next;
      done  <= done_next;
    end
  end

  assign Q             = q;
  assign TerminalCount = tc;
  assign Done          = done;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed testbench for prescaled_updown_counter (SIZE=16, PRESCALE_BITS=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the next edge.
module tb_prescaled_updown_counter;

  localparam int SIZE = 16;
  localparam int PB   = 8;

  logic            Clock = 1'b0;
  logic            Reset, Enable, Load, Direction;
  logic [SIZE-1:0] LoadValue, Limit;
  logic [1:0]      Mode;
  logic [PB-1:0]   Prescale;
  logic [SIZE-1:0] Q;
  logic            TerminalCount, Done;

  int n_checks = 0;
  int n_fail   = 0;

  prescaled_updown_counter #(.SIZE(SIZE), .PRESCALE_BITS(PB)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load),
    .LoadValue(LoadValue), .Direction(Direction), .Mode(Mode),
    .Limit(Limit), .Prescale(Prescale), .Q(Q),
    .TerminalCount(TerminalCount), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Load a value with Enable low, leaving Load deasserted afterwards.
  task automatic do_load(input logic [SIZE-1:0] v);
    Enable    = 1'b0;
    Load      = 1'b1;
    LoadValue = v;
    step();
    Load = 1'b0;
  endtask

  // Run n enabled steps, checking Q/TerminalCount/Done after each edge.
  task automatic run_seq(input string tag, input int n, input int exp_q[],
                         input int exp_tc[], input int exp_done[]);
    Enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s q[%0d]", tag, i), 32'(Q), 32'(exp_q[i]));
      check($sformatf("%s tc[%0d]", tag, i), 32'(TerminalCount), 32'(exp_tc[i]));
      check($sformatf("%s done[%0d]", tag, i), 32'(Done), 32'(exp_done[i]));
    end
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; Load = 1'b0; LoadValue = '0;
    Direction = 1'b0; Mode = 2'b00; Limit = 16'd7; Prescale = '0;
    step(); step();
    Reset = 1'b0;
    check("reset q", 32'(Q), 0);
    check("reset tc", 32'(TerminalCount), 0);
    check("reset done", 32'(Done), 0);

    // Wrap, up, limit 7, from 5.
    do_load(16'd5);
    check("wrap load q", 32'(Q), 5);
    run_seq("wrap", 4, '{6, 7, 0, 1}, '{0, 0, 1, 0}, '{0, 0, 1, 1});

    // Prescale 3: step every 4 cycles; 2 disabled cycles stretch one period.
    Limit = 16'd100; Prescale = 8'd3;
    do_load(16'd0);
    Enable = 1'b1;
    step(); step(); step();
    check("pre before tick", 32'(Q), 0);
    step();
    check("pre first tick", 32'(Q), 1);
    step(); step();
    Enable = 1'b0;
    step(); step();
    Enable = 1'b1;
    step();
    check("pre stretched hold", 32'(Q), 1);
    step();
    check("pre stretched tick", 32'(Q), 2);

    // Saturate, down from 2, then flip direction.
    Prescale = '0; Mode = 2'b01; Direction = 1'b1;
    do_load(16'd2);
    run_seq("sat", 4, '{1, 0, 0, 0}, '{0, 0, 1, 1}, '{0, 0, 1, 1});
    Direction = 1'b0;
    run_seq("sat up", 2, '{1, 2}, '{0, 0}, '{1, 1});

    // One-shot, up, limit 3.
    Mode = 2'b10; Limit = 16'd3;
    do_load(16'd0);
    run_seq("os", 5, '{1, 2, 3, 3, 3}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 1});
    Direction = 1'b1;
    run_seq("os frozen", 2, '{3, 3}, '{0, 0}, '{1, 1});
    Load = 1'b1; LoadValue = 16'd1; Direction = 1'b0;
    step();
    Load = 1'b0;
    check("os reload q", 32'(Q), 1);
    check("os reload done", 32'(Done), 0);
    check("os reload tc", 32'(TerminalCount), 0);
    step();
    check("os restart q", 32'(Q), 2);

    // Auto-reload 10..12.
    Mode = 2'b11; Limit = 16'd12;
    do_load(16'd10);
    check("ar load q", 32'(Q), 10);
    run_seq("ar", 6, '{11, 12, 10, 11, 12, 10}, '{0, 0, 1, 0, 0, 1},
            '{0, 0, 1, 1, 1, 1});

    // Reset beats Load and a pending tick.
    Enable = 1'b1; Reset = 1'b1; Load = 1'b1; LoadValue = 16'd9;
    step();
    Reset = 1'b0; Load = 1'b0;
    check("rst prio q", 32'(Q), 0);
    check("rst prio done", 32'(Done), 0);
    check("rst prio tc", 32'(TerminalCount), 0);

    // Limit 0 in wrap mode: terminal on every tick at 0.
    Mode = 2'b00; Limit = 16'd0; Direction = 1'b0;
    run_seq("lim0", 2, '{0, 0}, '{1, 1}, '{1, 1});

    // Load beats a terminal tick.
    Load = 1'b1; LoadValue = 16'd7;
    step();
    Load = 1'b0; Enable = 1'b0;
    check("load prio q", 32'(Q), 7);
    check("load prio tc", 32'(TerminalCount), 0);
    check("load prio done", 32'(Done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
